// File: rtl/udp_fragment_slot_buffer_pkg.sv
// Shared types and constants for the UDP fragment slot buffer.
package udp_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ID_W   = 16;
    localparam int unsigned DROP_W = 16;

    localparam logic [15:0] STALE_LIMIT_DEFAULT = 16'd50000;

    typedef enum logic [1:0] {
        S_EMPTY    = 2'd0,
        S_FILLING  = 2'd1,
        S_COMPLETE = 2'd2,
        S_DRAINING = 2'd3
    } slot_state_type;

    typedef enum logic {
        R_IDLE   = 1'b0,
        R_STREAM = 1'b1
    } read_state_type;

endpackage

// File: rtl/udp_fragment_slot_buffer_if.sv
// Push stream from the UDP handler, slot status back to it, and the byte output stream.
interface udp_fragment_slot_buffer_if
    import udp_pkg::*;
#(
    parameter int unsigned FRAGMENT_SLOTS = 2
);
    logic [BYTE_W-1:0]                          push_data;
    logic [FRAGMENT_SLOTS-1:0]                  push_data_valid;
    logic [FRAGMENT_SLOTS-1:0]                  push_data_last;
    logic [ID_W-1:0]                            packet_id;
    logic [FRAGMENT_SLOTS-1:0]                  fragment_slot_empty;
    logic [FRAGMENT_SLOTS-1:0][ID_W-1:0]        fragment_slot_packet_id;
    logic [BYTE_W-1:0]                          out_data;
    logic                                       out_data_valid;
    logic                                       out_data_last;
    logic [ID_W-1:0]                            out_packet_id;
    logic                                       out_data_ready;
    logic [DROP_W-1:0]                          drop_count;
    logic                                       protocol_error;

    modport slave (
        input  push_data, push_data_valid, push_data_last, packet_id, out_data_ready,
        output fragment_slot_empty, fragment_slot_packet_id, out_data, out_data_valid,
               out_data_last, out_packet_id, drop_count, protocol_error
    );

    modport master (
        output push_data, push_data_valid, push_data_last, packet_id, out_data_ready,
        input  fragment_slot_empty, fragment_slot_packet_id, out_data, out_data_valid,
               out_data_last, out_packet_id, drop_count, protocol_error
    );
endinterface

// File: rtl/udp_fragment_slot_buffer_slot.sv
// One reassembly slot: byte RAM, fill count, sticky overflow, captured id, stale timer and slot state.
module udp_fragment_slot
    import udp_pkg::*;
#(
    parameter int unsigned SLOT_DEPTH  = 2048,
    parameter logic [15:0] STALE_LIMIT = STALE_LIMIT_DEFAULT
)(
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          i_valid,
    input  logic                          i_last,
    input  logic [BYTE_W-1:0]             i_data,
    input  logic [ID_W-1:0]               i_packet_id,
    input  logic [$clog2(SLOT_DEPTH)-1:0] i_rd_ptr,
    input  logic                          i_drain_start,
    input  logic                          i_free,
    output slot_state_type                o_state,
    output logic [$clog2(SLOT_DEPTH):0]   o_count,
    output logic [ID_W-1:0]               o_packet_id,
    output logic [BYTE_W-1:0]             o_rd_data_c,
    output logic                          o_discard_c,
    output logic                          o_protocol_error_c
);
    localparam int unsigned AW = $clog2(SLOT_DEPTH);
    localparam int unsigned CW = AW + 1;

    slot_state_type    r_state;
    logic [CW-1:0]     r_count;
    logic              r_overflow;
    logic [ID_W-1:0]   r_packet_id;
    logic [15:0]       r_timer;
    logic [BYTE_W-1:0] r_mem [SLOT_DEPTH];

    logic          w_open, w_wr, w_full, w_mem_we, w_ovf_nxt, w_close, w_close_drop, w_stale;
    logic [CW-1:0] w_count_nxt;

    assign w_open       = (r_state == S_EMPTY) || (r_state == S_FILLING);
    assign w_wr         = i_valid && w_open;
    assign w_full       = (r_count == CW'(SLOT_DEPTH));
    assign w_mem_we     = w_wr && !w_full;
    assign w_count_nxt  = w_mem_we ? r_count + CW'(1) : r_count;
    assign w_ovf_nxt    = r_overflow || (w_wr && w_full);
    assign w_close      = i_last && w_open;
    assign w_close_drop = w_close && ((w_count_nxt == '0) || w_ovf_nxt);
    assign w_stale      = (r_state == S_FILLING) && !i_valid && !i_last
                          && (r_timer == STALE_LIMIT - 16'd1);

    assign o_discard_c        = w_close_drop || w_stale;
    assign o_protocol_error_c = (i_valid || i_last) && !w_open;
    assign o_rd_data_c        = r_mem[i_rd_ptr];
    assign o_state            = r_state;
    assign o_count            = r_count;
    assign o_packet_id        = r_packet_id;

    always_ff @(posedge clock) begin
        if (w_mem_we) r_mem[r_count[AW-1:0]] <= i_data;
    end

    // A same-cycle byte is accounted for before the close decision.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_EMPTY;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_packet_id <= '0;
            r_timer     <= '0;
        end else begin
            case (r_state)
                S_EMPTY, S_FILLING: begin
                    if (o_discard_c) begin
                        r_state     <= S_EMPTY;
                        r_count     <= '0;
                        r_overflow  <= 1'b0;
                        r_packet_id <= '0;
                        r_timer     <= '0;
                    end else if (w_close) begin
                        r_state    <= S_COMPLETE;
                        r_count    <= w_count_nxt;
                        r_overflow <= w_ovf_nxt;
                        if (r_state == S_EMPTY) r_packet_id <= i_packet_id;
                    end else if (w_wr) begin
                        r_state    <= S_FILLING;
                        r_count    <= w_count_nxt;
                        r_overflow <= w_ovf_nxt;
                        r_timer    <= '0;
                        if (r_state == S_EMPTY) r_packet_id <= i_packet_id;
                    end else if (r_state == S_FILLING) begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                S_COMPLETE: begin
                    if (i_drain_start) r_state <= S_DRAINING;
                end
                S_DRAINING: begin
                    if (i_free) begin
                        r_state     <= S_EMPTY;
                        r_count     <= '0;
                        r_overflow  <= 1'b0;
                        r_packet_id <= '0;
                        r_timer     <= '0;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end
endmodule

// File: rtl/udp_fragment_slot_buffer.sv
// Reassembly slot array with round-robin readout of completed datagrams and a saturating drop counter.
module udp_fragment_slot_buffer
    import udp_pkg::*;
#(
    parameter int unsigned FRAGMENT_SLOTS = 2,
    parameter int unsigned SLOT_DEPTH     = 2048,
    parameter logic [15:0] STALE_LIMIT    = STALE_LIMIT_DEFAULT
)(
    input  logic                     clock,
    input  logic                     reset_n,
    udp_fragment_slot_buffer_if.slave io_bus
);
    localparam int unsigned NS = FRAGMENT_SLOTS;
    localparam int unsigned AW = $clog2(SLOT_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(NS);
    localparam int unsigned DW = SW + 1;

    logic [NS-1:0]     w_valid_oh, w_last_oh, w_drain_start, w_free, w_discard, w_perr;
    slot_state_type    w_state   [NS];
    logic [CW-1:0]     w_count   [NS];
    logic [ID_W-1:0]   w_id      [NS];
    logic [BYTE_W-1:0] w_rd_data [NS];

    read_state_type    r_rstate;
    logic [SW-1:0]     r_sel, r_last_served;
    logic [AW-1:0]     r_rd_ptr;
    logic [BYTE_W-1:0] r_out_data;
    logic              r_out_valid, r_out_last, r_protocol_error;
    logic [ID_W-1:0]   r_out_packet_id;
    logic [DROP_W-1:0] r_drop_count;

    logic              w_pick_valid, w_load, w_finish, w_beat_last;
    logic [SW-1:0]     w_pick;
    logic [DW-1:0]     w_drop_inc;
    logic [DROP_W:0]   w_drop_sum;

    // Non-one-hot strobes collapse to their lowest set bit.
    assign w_valid_oh = io_bus.push_data_valid & (~io_bus.push_data_valid + NS'(1));
    assign w_last_oh  = io_bus.push_data_last  & (~io_bus.push_data_last  + NS'(1));

    for (genvar g = 0; g < NS; g++) begin : g_slot
        udp_fragment_slot #(
            .SLOT_DEPTH (SLOT_DEPTH),
            .STALE_LIMIT(STALE_LIMIT)
        ) u_slot (
            .clock             (clock),
            .reset_n           (reset_n),
            .i_valid           (w_valid_oh[g]),
            .i_last            (w_last_oh[g]),
            .i_data            (io_bus.push_data),
            .i_packet_id       (io_bus.packet_id),
            .i_rd_ptr          (r_rd_ptr),
            .i_drain_start     (w_drain_start[g]),
            .i_free            (w_free[g]),
            .o_state           (w_state[g]),
            .o_count           (w_count[g]),
            .o_packet_id       (w_id[g]),
            .o_rd_data_c       (w_rd_data[g]),
            .o_discard_c       (w_discard[g]),
            .o_protocol_error_c(w_perr[g])
        );
        assign io_bus.fragment_slot_empty[g]     = (w_state[g] == S_EMPTY);
        assign io_bus.fragment_slot_packet_id[g] = w_id[g];
    end

    // Search starts one past the slot served last.
    always_comb begin
        int unsigned idx;
        idx          = 0;
        w_pick_valid = 1'b0;
        w_pick       = '0;
        for (int unsigned off = 1; off <= NS; off++) begin
            idx = (32'(r_last_served) + off) % NS;
            if (!w_pick_valid && (w_state[SW'(idx)] == S_COMPLETE)) begin
                w_pick_valid = 1'b1;
                w_pick       = SW'(idx);
            end
        end
    end

    assign w_load      = !r_out_valid || io_bus.out_data_ready;
    assign w_finish    = (r_rstate == R_STREAM) && r_out_valid && io_bus.out_data_ready && r_out_last;
    assign w_beat_last = ({1'b0, r_rd_ptr} == w_count[r_sel] - CW'(1));

    always_comb begin
        w_drain_start = '0;
        w_free        = '0;
        if ((r_rstate == R_IDLE) && w_pick_valid) w_drain_start[w_pick] = 1'b1;
        if (w_finish) w_free[r_sel] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rstate        <= R_IDLE;
            r_sel           <= '0;
            r_last_served   <= SW'(NS - 1);
            r_rd_ptr        <= '0;
            r_out_data      <= '0;
            r_out_valid     <= 1'b0;
            r_out_last      <= 1'b0;
            r_out_packet_id <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_pick_valid) begin
                        r_sel           <= w_pick;
                        r_rd_ptr        <= '0;
                        r_out_packet_id <= w_id[w_pick];
                        r_rstate        <= R_STREAM;
                    end
                end
                R_STREAM: begin
                    if (w_finish) begin
                        r_out_valid   <= 1'b0;
                        r_out_last    <= 1'b0;
                        r_last_served <= r_sel;
                        r_rstate      <= R_IDLE;
                    end else if (w_load) begin
                        r_out_data  <= w_rd_data[r_sel];
                        r_out_last  <= w_beat_last;
                        r_out_valid <= 1'b1;
                        r_rd_ptr    <= r_rd_ptr + AW'(1);
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign w_drop_inc = DW'($countones(w_discard));
    assign w_drop_sum = (DROP_W + 1)'(r_drop_count) + (DROP_W + 1)'(w_drop_inc);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_count     <= '0;
            r_protocol_error <= 1'b0;
        end else begin
            r_drop_count     <= w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
            r_protocol_error <= |w_perr;
        end
    end

    assign io_bus.out_data       = r_out_data;
    assign io_bus.out_data_valid = r_out_valid;
    assign io_bus.out_data_last  = r_out_last;
    assign io_bus.out_packet_id  = r_out_packet_id;
    assign io_bus.drop_count     = r_drop_count;
    assign io_bus.protocol_error = r_protocol_error;
endmodule

// File: tb/tb_udp_fragment_slot_buffer.sv
// Directed bench for udp_fragment_slot_buffer with 2 slots, 8-byte depth and a 16-cycle stale limit.
module tb_udp_fragment_slot_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    udp_fragment_slot_buffer_if #(.FRAGMENT_SLOTS(2)) bus ();

    udp_fragment_slot_buffer #(
        .FRAGMENT_SLOTS(2),
        .SLOT_DEPTH    (8),
        .STALE_LIMIT   (16'd16)
    ) dut (
        .clock  (clk),
        .reset_n(rst_n),
        .io_bus (bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    // Accepted beats packed as {last, id, data}.
    logic [24:0] q_beat[$];
    logic [24:0] exp_beat[$];

    // One clock: record the beat accepted at this edge, then check a stalled beat held steady.
    task automatic step();
        logic hp;
        logic [7:0] hd;
        logic hl;
        if (bus.out_data_valid === 1'b1 && bus.out_data_ready === 1'b1)
            q_beat.push_back({bus.out_data_last, bus.out_packet_id, bus.out_data});
        hp = (bus.out_data_valid === 1'b1) && (bus.out_data_ready === 1'b0);
        hd = bus.out_data;
        hl = bus.out_data_last;
        @(posedge clk);
        #1;
        bus.push_data_valid = '0;
        bus.push_data_last  = '0;
        if (hp) begin
            n_chk++;
            if (bus.out_data_valid !== 1'b1 || bus.out_data !== hd || bus.out_data_last !== hl) begin
                n_fail++;
                $display("FAIL hold_stable: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                         bus.out_data_valid, bus.out_data, bus.out_data_last, hd, hl);
            end
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] l, input logic [7:0] d);
        bus.push_data_valid = v;
        bus.push_data_last  = l;
        bus.push_data       = d;
        step();
    endtask

    task automatic compare_beats(input string name);
        logic [24:0] got;
        n_chk++;
        if (q_beat.size() != exp_beat.size()) begin
            n_fail++;
            $display("FAIL %s_len: got %0d beats, required %0d", name, q_beat.size(), exp_beat.size());
        end
        foreach (exp_beat[i]) begin
            got = (i < q_beat.size()) ? q_beat[i] : 25'bx;
            n_chk++;
            if (got !== exp_beat[i]) begin
                n_fail++;
                $display("FAIL %s_beat%0d: got {last,id,data}=%h, required %h", name, i, got, exp_beat[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.push_data = '0; bus.push_data_valid = '0; bus.push_data_last = '0;
        bus.packet_id = '0; bus.out_data_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (bus.fragment_slot_empty !== 2'b11) begin n_fail++;
            $display("FAIL rst_empty: got %b, required 11", bus.fragment_slot_empty); end
        n_chk++; if (bus.fragment_slot_packet_id !== 32'h0) begin n_fail++;
            $display("FAIL rst_ids: got %h, required 0", bus.fragment_slot_packet_id); end
        n_chk++; if ({bus.out_data_valid, bus.out_data_last, bus.out_data} !== 10'h0) begin n_fail++;
            $display("FAIL rst_out: got v=%b l=%b d=%h, required 0", bus.out_data_valid, bus.out_data_last, bus.out_data); end
        n_chk++; if (bus.out_packet_id !== 16'h0) begin n_fail++;
            $display("FAIL rst_out_id: got %h, required 0", bus.out_packet_id); end
        n_chk++; if (bus.drop_count !== 16'h0 || bus.protocol_error !== 1'b0) begin n_fail++;
            $display("FAIL rst_cnt: got drop=%h perr=%b, required 0/0", bus.drop_count, bus.protocol_error); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        q_beat.delete(); exp_beat.delete();
        bus.packet_id = 16'hBEEF;
        drive(2'b01, 2'b00, 8'h11);
        n_chk++; if (bus.fragment_slot_empty !== 2'b10 || bus.fragment_slot_packet_id[0] !== 16'hBEEF) begin n_fail++;
            $display("FAIL basic_capture: got empty=%b id0=%h, required 10/BEEF", bus.fragment_slot_empty, bus.fragment_slot_packet_id[0]); end
        drive(2'b01, 2'b00, 8'h22);
        drive(2'b01, 2'b00, 8'h33);
        drive(2'b00, 2'b01, 8'h00);
        n_chk++; if (bus.out_data_valid !== 1'b0) begin n_fail++;
            $display("FAIL basic_early: got valid=%b, required 0", bus.out_data_valid); end
        step(); step();
        n_chk++; if (bus.out_data_valid !== 1'b1 || bus.out_data !== 8'h11 || bus.out_packet_id !== 16'hBEEF) begin n_fail++;
            $display("FAIL basic_latency: got v=%b d=%h id=%h, required 1/11/BEEF", bus.out_data_valid, bus.out_data, bus.out_packet_id); end
        repeat (6) step();
        exp_beat.push_back({1'b0, 16'hBEEF, 8'h11});
        exp_beat.push_back({1'b0, 16'hBEEF, 8'h22});
        exp_beat.push_back({1'b1, 16'hBEEF, 8'h33});
        compare_beats("basic");
        n_chk++; if (bus.fragment_slot_empty !== 2'b11 || bus.fragment_slot_packet_id[0] !== 16'h0) begin n_fail++;
            $display("FAIL basic_freed: got empty=%b id0=%h, required 11/0", bus.fragment_slot_empty, bus.fragment_slot_packet_id[0]); end
    endtask

    task automatic test_last_with_byte();
        q_beat.delete(); exp_beat.delete();
        bus.packet_id = 16'h1234;
        drive(2'b10, 2'b00, 8'hA1);
        drive(2'b10, 2'b00, 8'hA2);
        drive(2'b10, 2'b00, 8'hA3);
        drive(2'b10, 2'b10, 8'h44);
        repeat (10) step();
        exp_beat.push_back({1'b0, 16'h1234, 8'hA1});
        exp_beat.push_back({1'b0, 16'h1234, 8'hA2});
        exp_beat.push_back({1'b0, 16'h1234, 8'hA3});
        exp_beat.push_back({1'b1, 16'h1234, 8'h44});
        compare_beats("lastbyte");
    endtask

    task automatic test_overflow();
        q_beat.delete(); exp_beat.delete();
        bus.packet_id = 16'h5555;
        for (int i = 1; i <= 9; i++) drive(2'b01, 2'b00, 8'(i));
        drive(2'b00, 2'b01, 8'h00);
        repeat (6) step();
        compare_beats("overflow");
        n_chk++; if (bus.drop_count !== 16'd1 || bus.fragment_slot_empty !== 2'b11) begin n_fail++;
            $display("FAIL overflow_drop: got drop=%0d empty=%b, required 1/11", bus.drop_count, bus.fragment_slot_empty); end
    endtask

    task automatic test_stale();
        drive(2'b10, 2'b00, 8'hC1);
        drive(2'b10, 2'b00, 8'hC2);
        repeat (15) step();
        n_chk++; if (bus.fragment_slot_empty !== 2'b01 || bus.drop_count !== 16'd1) begin n_fail++;
            $display("FAIL stale_early: got empty=%b drop=%0d, required 01/1", bus.fragment_slot_empty, bus.drop_count); end
        step();
        n_chk++; if (bus.fragment_slot_empty !== 2'b11 || bus.drop_count !== 16'd2) begin n_fail++;
            $display("FAIL stale_free: got empty=%b drop=%0d, required 11/2", bus.fragment_slot_empty, bus.drop_count); end
    endtask

    // Slot1 goes stale in the same cycle an empty datagram is closed on slot0.
    task automatic test_double_drop();
        drive(2'b10, 2'b00, 8'hD1);
        repeat (15) step();
        drive(2'b00, 2'b01, 8'h00);
        n_chk++; if (bus.drop_count !== 16'd4 || bus.fragment_slot_empty !== 2'b11) begin n_fail++;
            $display("FAIL double_drop: got drop=%0d empty=%b, required 4/11", bus.drop_count, bus.fragment_slot_empty); end
    endtask

    task automatic test_round_robin();
        logic refilled;
        refilled = 1'b0;
        q_beat.delete(); exp_beat.delete();
        bus.out_data_ready = 1'b1;
        bus.packet_id = 16'h0A0A; drive(2'b01, 2'b00, 8'h51);
        bus.packet_id = 16'h0B0B; drive(2'b10, 2'b00, 8'h61);
        drive(2'b11, 2'b00, 8'h52);
        drive(2'b10, 2'b00, 8'h62);
        drive(2'b10, 2'b01, 8'h63);
        drive(2'b00, 2'b10, 8'h00);
        for (int i = 0; i < 60 && q_beat.size() < 6; i++) begin
            bus.out_data_ready = ~bus.out_data_ready;
            if (!refilled && bus.fragment_slot_empty[0] === 1'b1) begin
                refilled = 1'b1;
                bus.packet_id = 16'h0C0C;
                bus.push_data_valid = 2'b01;
                bus.push_data_last  = 2'b01;
                bus.push_data       = 8'h71;
            end
            step();
        end
        bus.out_data_ready = 1'b1;
        n_chk++; if (refilled !== 1'b1) begin n_fail++;
            $display("FAIL rr_refill: got slot0 freed=%b, required 1", refilled); end
        exp_beat.push_back({1'b0, 16'h0A0A, 8'h51});
        exp_beat.push_back({1'b1, 16'h0A0A, 8'h52});
        exp_beat.push_back({1'b0, 16'h0B0B, 8'h61});
        exp_beat.push_back({1'b0, 16'h0B0B, 8'h62});
        exp_beat.push_back({1'b1, 16'h0B0B, 8'h63});
        exp_beat.push_back({1'b1, 16'h0C0C, 8'h71});
        compare_beats("rr");
    endtask

    task automatic test_protocol_error();
        int w;
        q_beat.delete(); exp_beat.delete();
        bus.packet_id = 16'h0D0D;
        drive(2'b01, 2'b00, 8'h81);
        drive(2'b01, 2'b00, 8'h82);
        drive(2'b01, 2'b00, 8'h83);
        drive(2'b01, 2'b01, 8'h84);
        w = 0;
        while (bus.out_data_valid !== 1'b1 && w < 10) begin step(); w++; end
        n_chk++; if (bus.out_data_valid !== 1'b1) begin n_fail++;
            $display("FAIL perr_wait: got valid=%b after %0d cycles, required 1", bus.out_data_valid, w); end
        drive(2'b01, 2'b00, 8'hEE);
        n_chk++; if (bus.protocol_error !== 1'b1) begin n_fail++;
            $display("FAIL perr_pulse: got %b, required 1", bus.protocol_error); end
        step();
        n_chk++; if (bus.protocol_error !== 1'b0) begin n_fail++;
            $display("FAIL perr_clear: got %b, required 0", bus.protocol_error); end
        repeat (8) step();
        exp_beat.push_back({1'b0, 16'h0D0D, 8'h81});
        exp_beat.push_back({1'b0, 16'h0D0D, 8'h82});
        exp_beat.push_back({1'b0, 16'h0D0D, 8'h83});
        exp_beat.push_back({1'b1, 16'h0D0D, 8'h84});
        compare_beats("perr");
        n_chk++; if (bus.drop_count !== 16'd4 || bus.fragment_slot_empty !== 2'b11) begin n_fail++;
            $display("FAIL perr_after: got drop=%0d empty=%b, required 4/11", bus.drop_count, bus.fragment_slot_empty); end
    endtask

    task automatic test_reset_midstream();
        int w;
        bus.out_data_ready = 1'b0;
        bus.packet_id = 16'h0F0F;
        drive(2'b10, 2'b00, 8'hF1);
        drive(2'b10, 2'b00, 8'hF2);
        drive(2'b10, 2'b10, 8'hF3);
        w = 0;
        while (bus.out_data_valid !== 1'b1 && w < 10) begin step(); w++; end
        n_chk++; if (bus.out_data_valid !== 1'b1 || bus.out_data !== 8'hF1) begin n_fail++;
            $display("FAIL mid_wait: got v=%b d=%h, required 1/F1", bus.out_data_valid, bus.out_data); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if ({bus.out_data_valid, bus.out_data_last, bus.out_data, bus.out_packet_id} !== 26'h0) begin n_fail++;
            $display("FAIL mid_rst_out: got v=%b l=%b d=%h id=%h, required 0", bus.out_data_valid,
                     bus.out_data_last, bus.out_data, bus.out_packet_id); end
        n_chk++; if (bus.drop_count !== 16'h0 || bus.fragment_slot_empty !== 2'b11 || bus.fragment_slot_packet_id !== 32'h0) begin n_fail++;
            $display("FAIL mid_rst_state: got drop=%h empty=%b ids=%h, required 0/11/0", bus.drop_count,
                     bus.fragment_slot_empty, bus.fragment_slot_packet_id); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_data_ready = 1'b1;
        q_beat.delete();
        repeat (5) step();
        n_chk++; if (q_beat.size() != 0 || bus.out_data_valid !== 1'b0) begin n_fail++;
            $display("FAIL mid_abandon: got %0d beats valid=%b, required 0/0", q_beat.size(), bus.out_data_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_last_with_byte();
        test_overflow();
        test_stale();
        test_double_drop();
        test_round_robin();
        test_protocol_error();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule

// File: doc/udp_fragment_slot_buffer.md
Name: udp_fragment_slot_buffer

Overview:
- Sits directly downstream of the UDP receive handler and consumes its per-slot byte push stream (push_data, push_data_valid, push_data_last, packet_id).
- Holds FRAGMENT_SLOTS reassembly buffers and reports per-slot empty status and captured packet id back to the handler.
- Each completed datagram is streamed out byte-wise on a valid/ready interface, then its slot is freed.
- Overflowed, stale and empty datagrams are dropped and counted.

Parameters:
- FRAGMENT_SLOTS, 2, number of reassembly slots; must be ≥2.
- SLOT_DEPTH, 2048, bytes per slot; must be a power of 2.
- STALE_LIMIT, 16'd50000, idle cycles after which a FILLING slot is discarded.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- push_data  in  8  byte from handler.
- push_data_valid  in  FRAGMENT_SLOTS  one-hot write strobe selecting the slot.
- push_data_last  in  FRAGMENT_SLOTS  one-hot close strobe; may arrive alone or together with valid.
- packet_id  in  16  IPv4 identification; stable while the handler pushes.
- fragment_slot_empty  out  FRAGMENT_SLOTS  1 = slot in S_EMPTY.
- fragment_slot_packet_id  out  [FRAGMENT_SLOTS][16]  id captured at the first byte; 0 when empty.
- out_data  out  8  reassembled byte.
- out_data_valid  out  1  out_data valid.
- out_data_last  out  1  final byte of the datagram.
- out_packet_id  out  16  id of the datagram being streamed.
- out_data_ready  in  1  consumer accepts.
- drop_count  out  16  saturating count of discarded datagrams.
- protocol_error  out  1  one-cycle pulse when a push targets a COMPLETE or DRAINING slot.

Behaviour:
- Reset: one clock, asynchronous active-low reset_n. While reset_n is low:
  - all slots go to S_EMPTY, with count=0, overflow=0 and id=0;
  - fragment_slot_empty is all 1s and fragment_slot_packet_id is all 0;
  - out_data, out_data_valid, out_data_last, out_packet_id, drop_count and protocol_error are 0;
  - the read FSM goes to R_IDLE;
  - a reset mid-stream abandons the datagram with no last beat.
- Per-slot state machine S_EMPTY / S_FILLING / S_COMPLETE / S_DRAINING:
  - S_EMPTY + valid: write the byte at address 0, count=1, capture packet_id, go to S_FILLING. fragment_slot_empty and fragment_slot_packet_id update on the next edge.
  - S_FILLING + valid: write at address count, count+1.
  - At count==SLOT_DEPTH: the byte is dropped and the sticky overflow bit is set; count does not wrap.
  - Each valid reloads the slot's stale timer.
  - S_FILLING/S_EMPTY + last (with or without a same-cycle valid, whose byte is written first):
    - if the resulting count==0 or overflow=1: discard, go to S_EMPTY, drop_count+1;
    - otherwise go to S_COMPLETE.
  - S_FILLING with no valid for STALE_LIMIT cycles: discard, go to S_EMPTY, drop_count+1. The stale timer does not run in other states.
  - S_COMPLETE / S_DRAINING + valid or last: ignored, protocol_error pulses.
  - Only the lowest set bit of a non-one-hot strobe is honoured.
- Read FSM R_IDLE / R_STREAM:
  - R_IDLE: round-robin pick among S_COMPLETE slots, starting at the slot after the last one served.
  - On a pick: the slot goes to S_DRAINING, rd_ptr=0, out_packet_id is latched, go to R_STREAM.
  - R_STREAM: a beat is loaded when !out_data_valid || out_data_ready. Memory read is combinational on rd_ptr.
  - out_data_last=1 when rd_ptr==count-1.
  - After the last beat is accepted: the slot goes to S_EMPTY (id cleared, count=0) and the FSM returns to R_IDLE.
  - out_data_valid stays high with stable data/last until accepted.
  - First beat appears 2 cycles after the slot enters S_COMPLETE; back-to-back streaming is 1 byte/cycle with ready held high.
- Simultaneous events:
  - a slot may be filling while another drains;
  - a freeing slot is re-fillable on the cycle after it shows empty;
  - a drop and a discard in the same cycle add 2 to drop_count;
  - drop_count saturates at 16'hFFFF.

Decomposition:
- Shared package udp_pkg:
  - slot_state_type enum;
  - read_state_type enum;
  - STALE_LIMIT default constant.
- One natural sub-module: udp_fragment_slot (single slot: byte RAM, count, overflow, id, stale cycle_timer, state). Instantiated FRAGMENT_SLOTS times.
- The top level holds the read FSM, round-robin arbiter and drop counter.

Test Plan:
- Push 0x11,0x22,0x33 to slot0 with id 0xBEEF, then last alone. Required: fragment_slot_empty=10, id[0]=0xBEEF; output bytes 11,22,33 with last on 33, out_packet_id=0xBEEF; slot0 empty again.
- Last coincident with the 4th byte 0x44 on slot1. Required: 4 bytes out, last on 0x44.
- SLOT_DEPTH=8, push 9 bytes then last. Required: no output, drop_count=1, slot empty.
- Push 2 bytes, then idle STALE_LIMIT=16 cycles. Required: slot freed on cycle 16, drop_count=1.
- Complete slot0 and slot1 together with out_data_ready toggling 1/0. Required: slot0 streamed fully before slot1, data held stable while ready=0; next completion on slot0 served after slot1.
- Push to slot0 while it is DRAINING. Required: protocol_error pulses once, stream unaffected; assert reset_n mid-stream, outputs 0 asynchronously.
